// File: rtl/offset_aabb.sv
// offset_aabb: translates an axis-aligned bounding box by a 3-component
// signed fixed-point offset, saturating each component, in one registered
// pipeline stage. Packing for every 3*WIDTH bus: x = [3W-1:2W],
// y = [2W-1:W], z = [W-1:0].
//
// Valid semantics: in_valid qualifies offset/aabb_min/aabb_max for the
// rising edge at which it is sampled; out_valid is high for exactly the cycle
// after such an edge. There is no ready/backpressure, so the block accepts
// one box every cycle. On edges with in_valid=0 the result registers hold.
module offset_aabb #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3*WIDTH-1:0]   offset,
  input  logic [3*WIDTH-1:0]   aabb_min,
  input  logic [3*WIDTH-1:0]   aabb_max,
  output logic                 out_valid,
  output logic [3*WIDTH-1:0]   out_min,
  output logic [3*WIDTH-1:0]   out_max,
  output logic [5:0]           out_overflow,
  output logic                 out_inverted
);

  // FRAC only documents the binary point; addition is independent of it.
  if (FRAC < 0 || FRAC > WIDTH) begin : g_bad_frac
    $error("offset_aabb: FRAC must lie in [0, WIDTH]");
  end

  // Signed add with saturation; returns {overflow, result}.
  // A WIDTH+1-bit sum overflows exactly when its top two bits differ;
  // the top bit then gives the direction of the overflow.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] min_v;
    s     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    max_v = {1'b0, {(WIDTH-1){1'b1}}};
    min_v = {1'b1, {(WIDTH-1){1'b0}}};
    if (s[WIDTH] != s[WIDTH-1]) begin
      return {1'b1, (s[WIDTH] ? min_v : max_v)};
    end
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  logic [3*WIDTH-1:0] nxt_min;
  logic [3*WIDTH-1:0] nxt_max;
  logic [5:0]         nxt_ovf;
  logic               nxt_inv;

  // Per-axis saturating translate of both corners plus inversion detect.
  always_comb begin
    logic [WIDTH:0] r_min;
    logic [WIDTH:0] r_max;
    nxt_min = '0;
    nxt_max = '0;
    nxt_ovf = '0;
    nxt_inv = 1'b0;
    r_min   = '0;
    r_max   = '0;
    for (int d = 0; d < 3; d++) begin
      r_min = sat_add(aabb_min[(2-d)*WIDTH +: WIDTH], offset[(2-d)*WIDTH +: WIDTH]);
      r_max = sat_add(aabb_max[(2-d)*WIDTH +: WIDTH], offset[(2-d)*WIDTH +: WIDTH]);
      nxt_min[(2-d)*WIDTH +: WIDTH] = r_min[WIDTH-1:0];
      nxt_max[(2-d)*WIDTH +: WIDTH] = r_max[WIDTH-1:0];
      nxt_ovf[d]     = r_min[WIDTH];
      nxt_ovf[3 + d] = r_max[WIDTH];
      // Inversion is judged on the saturated values; min/max are never swapped.
      if ($signed(r_min[WIDTH-1:0]) > $signed(r_max[WIDTH-1:0])) begin
        nxt_inv = 1'b1;
      end
    end
  end

  // Result registers: load on valid input, hold otherwise; reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_min      <= '0;
      out_max      <= '0;
      out_overflow <= '0;
      out_inverted <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_min      <= nxt_min;
        out_max      <= nxt_max;
        out_overflow <= nxt_ovf;
        out_inverted <= nxt_inv;
      end
    end
  end

endmodule

// File: tb/tb_offset_aabb.sv
// Bench for offset_aabb: directed steps in one initial block, a scoreboard
// queue of expected results filled at the sampling edge and drained when the
// DUT raises out_valid, and an independent integer reference model.
module tb_offset_aabb;

  localparam int W  = 32;
  localparam int EW = 6*W + 7;   // {min, max, overflow, inverted}

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [3*W-1:0] offset;
  logic [3*W-1:0] aabb_min;
  logic [3*W-1:0] aabb_max;
  logic           out_valid;
  logic [3*W-1:0] out_min;
  logic [3*W-1:0] out_max;
  logic [5:0]     out_overflow;
  logic           out_inverted;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;
  int            n_checks;
  int            n_errors;

  offset_aabb #(.WIDTH(W), .FRAC(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .offset       (offset),
    .aabb_min     (aabb_min),
    .aabb_max     (aabb_max),
    .out_valid    (out_valid),
    .out_min      (out_min),
    .out_max      (out_max),
    .out_overflow (out_overflow),
    .out_inverted (out_inverted)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 64-bit integer add, clamp, compare.
  function automatic logic [EW-1:0] model(input logic [3*W-1:0] off,
                                          input logic [3*W-1:0] mn,
                                          input logic [3*W-1:0] mx);
    longint   hi;
    longint   lo;
    longint   s;
    longint   rmn;
    longint   rmx;
    logic [3*W-1:0] omn;
    logic [3*W-1:0] omx;
    logic [5:0] ov;
    logic inv;
    hi  = 64'sd2147483647;
    lo  = -64'sd2147483648;
    omn = '0;
    omx = '0;
    ov  = '0;
    inv = 1'b0;
    for (int d = 0; d < 3; d++) begin
      s = longint'($signed(mn[(2-d)*W +: W])) + longint'($signed(off[(2-d)*W +: W]));
      rmn = s;
      if (s > hi) begin rmn = hi; ov[d] = 1'b1; end
      if (s < lo) begin rmn = lo; ov[d] = 1'b1; end
      s = longint'($signed(mx[(2-d)*W +: W])) + longint'($signed(off[(2-d)*W +: W]));
      rmx = s;
      if (s > hi) begin rmx = hi; ov[3+d] = 1'b1; end
      if (s < lo) begin rmx = lo; ov[3+d] = 1'b1; end
      if (rmn > rmx) inv = 1'b1;
      omn[(2-d)*W +: W] = rmn[W-1:0];
      omx[(2-d)*W +: W] = rmx[W-1:0];
    end
    return {omn, omx, ov, inv};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs,
                       input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge.
  task automatic drive(input logic rst, input logic v, input logic [3*W-1:0] off,
                       input logic [3*W-1:0] mn, input logic [3*W-1:0] mx);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    offset   = off;
    aabb_min = mn;
    aabb_max = mx;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  function automatic logic [W-1:0] edge_comp();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_0000 + $urandom_range(0, 32'h0002_0000);
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: push at the sampling edge, pop/compare just after it.
  always begin : scoreboard
    logic cap_rst;
    logic cap_v;
    logic [EW-1:0] e;
    @(posedge clk);
    cap_rst = reset;
    cap_v   = in_valid;
    if (cap_rst) exp_q.delete();
    else if (cap_v) exp_q.push_back(model(offset, aabb_min, aabb_max));
    #1;
    check("out_valid", EW'(out_valid), EW'(!cap_rst && cap_v));
    if (cap_rst) begin
      held = '0;
      check("reset_outs", {out_min, out_max, out_overflow, out_inverted}, '0);
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", EW'(exp_q.size()), EW'(1));
      end else begin
        e = exp_q.pop_front();
        held = e;
        check("result", {out_min, out_max, out_overflow, out_inverted}, e);
      end
    end else begin
      check("hold", {out_min, out_max, out_overflow, out_inverted}, held);
    end
  end

  // Directed stimulus
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    in_valid = 1'b1;
    offset   = {3{32'h1234_5678}};
    aabb_min = {3{32'h0BAD_F00D}};
    aabb_max = {3{32'h7777_7777}};

    // Reset held two edges with valid nonzero data
    @(posedge clk);
    drive(1'b1, 1'b1, {3{32'h0101_0101}}, {3{32'h2222_0000}}, {3{32'h3333_0000}});
    idle();

    // Basic translate
    drive(1'b0, 1'b1, {32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000},
                      {32'h0002_0000, 32'h0003_0000, 32'h0000_0000},
                      {32'h0005_0000, 32'h0004_0000, 32'h0001_0000});
    @(posedge clk); #2;
    check("basic_min", EW'(out_min), EW'({32'h0003_0000, 32'h0002_0000, 32'h0000_8000}));
    check("basic_max", EW'(out_max), EW'({32'h0006_0000, 32'h0003_0000, 32'h0001_8000}));
    check("basic_flags", EW'({out_valid, out_overflow, out_inverted}), EW'({1'b1, 6'b0, 1'b0}));

    // Saturation: positive on max.x, negative on min.y
    drive(1'b0, 1'b1, {32'h0002_0000, 32'hFFFF_0000, 32'h0000_0000},
                      {32'h0000_0000, 32'h8000_1000, 32'h0000_0000},
                      {32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000});
    @(posedge clk); #2;
    check("sat_max_x", EW'(out_max[3*W-1:2*W]), EW'(32'h7FFF_FFFF));
    check("sat_min_y", EW'(out_min[2*W-1:W]), EW'(32'h8000_0000));
    check("sat_ovf", EW'(out_overflow), EW'(6'b001010));

    // Inversion on z with zero offset
    drive(1'b0, 1'b1, '0, {32'h0, 32'h0, 32'h0001_0000}, {32'h0, 32'h0, 32'h0});
    @(posedge clk); #2;
    check("inv_flag", EW'({out_inverted, out_overflow}), EW'({1'b1, 6'b0}));
    check("inv_pass_min", EW'(out_min), EW'({32'h0, 32'h0, 32'h0001_0000}));
    idle();
    idle();

    // Streaming: four back-to-back boxes, then idle (last result held)
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, {$urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    end
    idle();
    idle();

    // Reset mid-stream, then resume
    drive(1'b0, 1'b1, {3{32'h0001_0000}}, {3{32'h0002_0000}}, {3{32'h0003_0000}});
    drive(1'b0, 1'b1, {3{32'hFFF0_0000}}, {3{32'h0010_0000}}, {3{32'h0020_0000}});
    drive(1'b1, 1'b1, {3{32'h4444_0000}}, {3{32'h5555_0000}}, {3{32'h6666_0000}});
    drive(1'b0, 1'b1, {32'h0000_1000, 32'h0000_2000, 32'h0000_3000},
                      {32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000},
                      {32'h0002_0000, 32'h0000_0000, 32'h0000_4000});
    @(posedge clk); #2;
    check("resume_min", EW'(out_min), EW'({32'h0001_1000, 32'hFFFF_2000, 32'h0000_3000}));
    idle();

    // Boundary-heavy random boxes with occasional bubbles
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0),
            {edge_comp(), edge_comp(), edge_comp()},
            {edge_comp(), edge_comp(), edge_comp()},
            {edge_comp(), edge_comp(), edge_comp()});
    end
    idle();
    idle();
    @(posedge clk); #2;
    check("queue_empty", EW'(exp_q.size()), EW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/offset_aabb.md
Name: offset_aabb

Overview:
- Translates an axis-aligned bounding box by a 3-component fixed-point offset: out.min = aabb.min + offset, out.max = aabb.max + offset, per axis.
- Sits in the ray core's BVH traversal path. Leaf/node AABBs fetched from BVH storage are moved into world position before ray-box tests.
- Single registered pipeline stage with a valid flag and per-axis saturation/overflow reporting.

Parameters:
- WIDTH, 32, bit width of one signed fixed-point component (two's complement; the fractional split is irrelevant to addition).
- FRAC, 16, fractional bits of the fixed-point format (documentation only; no effect on logic).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  offset/aabb inputs valid this cycle
- offset  in  3*WIDTH  translation vector; dim0 (x) = [3W-1:2W], dim1 (y) = [2W-1:W], dim2 (z) = [W-1:0]
- aabb_min  in  3*WIDTH  box minimum corner, same packing
- aabb_max  in  3*WIDTH  box maximum corner, same packing
- out_valid  out  1  result registers hold a new result
- out_min  out  3*WIDTH  translated minimum corner, same packing
- out_max  out  3*WIDTH  translated maximum corner, same packing
- out_overflow  out  6  saturation flags: bit d = min dim d saturated, bit 3+d = max dim d saturated
- out_inverted  out  1  set when any axis has out_min > out_max (signed) after saturation

Behaviour:
- Reset: on a rising edge with reset=1, out_valid=0, out_min=0, out_max=0, out_overflow=0, out_inverted=0. Reset overrides in_valid in the same cycle.
- Latency: exactly 1 cycle. Inputs sampled on edge N with in_valid=1 appear on outputs after edge N, with out_valid=1. Full throughput: one box per cycle. No backpressure.
- in_valid=0 at an edge: out_valid goes 0; out_min, out_max, out_overflow and out_inverted hold their previous values.
- Arithmetic per axis d, applied independently to min and max:
  - Signed WIDTH+1-bit sum of the component and offset[d].
  - If the sum exceeds 2^(W-1)-1, the result is 0x7FFF_FFFF (for W=32) and the corresponding overflow bit is set.
  - If the sum is below -2^(W-1), the result is 0x8000_0000 and the overflow bit is set.
  - Otherwise the result is the low W bits and the overflow bit is clear.
- out_inverted: computed on the saturated results, registered alongside them. The block never swaps or corrects min/max.
- Offset of zero passes the box through unchanged (identity).
- Mid-operation reset: the in-flight result is discarded; out_valid=0 after that edge. Normal operation resumes from the first edge with reset=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1 and nonzero data -> out_valid=0, all outputs 0.
- Basic translate (hex, W=32):
  - Stimulus: offset=(0x0001_0000, 0xFFFF_0000, 0x0000_8000), min=(0x0002_0000, 0x0003_0000, 0), max=(0x0005_0000, 0x0004_0000, 0x0001_0000), in_valid=1.
  - Response one cycle later: out_min=(0x0003_0000, 0x0002_0000, 0x0000_8000), out_max=(0x0006_0000, 0x0003_0000, 0x0001_8000), overflow=0, inverted=0, out_valid=1.
- Saturation:
  - Positive: max.x=0x7FFF_0000 with offset.x=0x0002_0000 -> out_max.x=0x7FFF_FFFF, out_overflow[3]=1.
  - Negative: min.y=0x8000_1000 with offset.y=0xFFFF_0000 -> out_min.y=0x8000_0000, out_overflow[1]=1.
- Inversion: min.z=0x0001_0000, max.z=0x0000_0000, offset 0 -> outputs pass through, out_inverted=1, out_overflow=0.
- Streaming: 4 back-to-back valid boxes followed by in_valid=0 -> 4 consecutive out_valid=1 results in order; then out_valid=0 with the last result held.
- Reset mid-stream: assert reset for one cycle during back-to-back inputs -> out_valid=0 after that edge; the next valid input produces a correct result one cycle later.
